// File: rtl/switch_ingress_arb_if.sv
// Bundle between the ingress cell builders' FIFOs, the arbiter and the switch core.
// Each per-port vector packs port k into slice k.
interface switch_ingress_arb_if;
    logic [3:0]   ptr_empty;
    logic [63:0]  ptr_dout;
    logic [3:0]   ptr_rd;
    logic [511:0] data_dout;
    logic [3:0]   data_rd;
    logic [127:0] o_cell_data;
    logic         o_cell_wr;
    logic         o_cell_sof;
    logic         o_cell_eof;
    logic [3:0]   o_cell_portmap;
    logic [1:0]   o_cell_src;
    logic         o_cell_bp;
    logic [15:0]  err_cnt;

    modport master (
        input  ptr_empty, ptr_dout, data_dout, o_cell_bp,
        output ptr_rd, data_rd, o_cell_data, o_cell_wr, o_cell_sof, o_cell_eof,
               o_cell_portmap, o_cell_src, err_cnt
    );

    modport slave (
        output ptr_empty, ptr_dout, data_dout, o_cell_bp,
        input  ptr_rd, data_rd, o_cell_data, o_cell_wr, o_cell_sof, o_cell_eof,
               o_cell_portmap, o_cell_src, err_cnt
    );
endinterface

// File: rtl/switch_ingress_arb.sv
// Frame-level round-robin arbiter: picks one ingress port with a pending pointer and
// streams that frame's cells back-to-back to the core, never interleaving frames.
module switch_ingress_arb #(
    parameter int NPORT = 4
) (
    input logic                  clk,
    input logic                  rst,
    switch_ingress_arb_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PTR_RD = 3'd1,
        S_LOAD   = 3'd2,
        S_XFER   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [5:0]  remain_q, remain_d;
    logic        first_q, first_d;
    logic        wr_q, wr_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic [3:0]  pm_q, pm_d;
    logic [1:0]  src_q, src_d;
    logic [15:0] err_q, err_d;

    logic [NPORT-1:0] req_s;
    logic [NPORT-1:0] ptr_rd_s;
    logic [NPORT-1:0] data_rd_s;
    logic             any_req_s;
    logic [1:0]       pick_s;
    logic [5:0]       cnt_s;
    logic [3:0]       ptr_pm_s;
    logic [127:0]     data_word_s;

    // Lowest offset from start wins, so scan offsets from the far end down to 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx  = start + 2'(i);
            pick = req[idx] ? idx : pick;
        end
        return pick;
    endfunction

    assign req_s       = ~bus.ptr_empty;
    assign any_req_s   = |req_s;
    assign pick_s      = rr_pick(req_s, rr_q);
    assign cnt_s       = bus.ptr_dout[{gnt_q, 4'b0000} +: 6];
    assign ptr_pm_s    = bus.ptr_dout[{gnt_q, 4'b1000} +: 4];
    assign data_word_s = bus.data_dout[{gnt_q, 7'b0000000} +: 128];

    // Next-state, FIFO pop and output-stage decode.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        remain_d  = remain_q;
        first_d   = first_q;
        pm_d      = pm_q;
        src_d     = src_q;
        err_d     = err_q;
        wr_d      = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        ptr_rd_s  = {NPORT{1'b0}};
        data_rd_s = {NPORT{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (any_req_s && !bus.o_cell_bp) begin
                    gnt_d   = pick_s;
                    state_d = S_PTR_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PTR_RD: begin
                ptr_rd_s = {{(NPORT-1){1'b0}}, 1'b1} << gnt_q;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                remain_d = cnt_s;
                pm_d     = ptr_pm_s;
                src_d    = gnt_q;
                rr_d     = gnt_q + 2'd1;
                first_d  = 1'b1;
                if (cnt_s == 6'd0) begin
                    err_d   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (!bus.o_cell_bp && (remain_q != 6'd0)) begin
                    data_rd_s = {{(NPORT-1){1'b0}}, 1'b1} << gnt_q;
                    remain_d  = remain_q - 6'd1;
                    first_d   = 1'b0;
                    wr_d      = 1'b1;
                    sof_d     = first_q;
                    eof_d     = (remain_q == 6'd1);
                    state_d   = (remain_q == 6'd1) ? S_DRAIN : S_XFER;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output-stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_q     <= 2'd0;
            gnt_q    <= 2'd0;
            remain_q <= 6'd0;
            first_q  <= 1'b0;
            wr_q     <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            pm_q     <= 4'd0;
            src_q    <= 2'd0;
            err_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            remain_q <= remain_d;
            first_q  <= first_d;
            wr_q     <= wr_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            pm_q     <= pm_d;
            src_q    <= src_d;
            err_q    <= err_d;
        end
    end

    // The data FIFO registers its own output, so the cell is muxed straight from it.
    assign bus.o_cell_data    = wr_q ? data_word_s : 128'd0;
    assign bus.o_cell_wr      = wr_q;
    assign bus.o_cell_sof     = sof_q;
    assign bus.o_cell_eof     = eof_q;
    assign bus.o_cell_portmap = pm_q;
    assign bus.o_cell_src     = src_q;
    assign bus.err_cnt        = err_q;
    assign bus.ptr_rd         = ptr_rd_s;
    assign bus.data_rd        = data_rd_s;
endmodule

// File: tb/tb_switch_ingress_arb.sv
// Bench for switch_ingress_arb: FIFO models per port, a frame-level round-robin reference
// model, a table of directed frames, hand-written corner sequences and random batches.
module tb_switch_ingress_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bp = 1'b0;
    logic fifo_clr = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    switch_ingress_arb_if bus();
    switch_ingress_arb dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [127:0] data;
        logic         sof;
        logic         eof;
        logic [3:0]   pm;
        logic [1:0]   src;
    } cell_t;
    typedef struct {
        logic [3:0] pm;
        int         cnt;
    } frm_t;
    typedef struct {
        int         port;
        logic [3:0] pm;
        int         cnt;
        int         exp_cells;
        int         exp_err;
    } vec_t;

    // FIFO storage: initial code owns the write indices, the read process owns the read indices
    logic [15:0]  ptr_mem  [4][64];
    logic [127:0] data_mem [4][1024];
    int           ptr_wr [4];
    int           dat_wr [4];
    int           ptr_rdi[4];
    int           dat_rdi[4];
    logic [15:0]  ptr_dout_r[4];
    logic [127:0] data_r[4];

    frm_t         mq[4][$];
    logic [127:0] mdata[4][$];
    cell_t        exp_q[$];
    int           model_rr = 0;
    int           err_exp = 0;
    int           serial = 0;

    cell_t obs_q[$];
    int    obs_cyc[$];
    int    ptr_cyc_q[$];
    int    ptr_port_q[$];
    int    n_data_rd = 0;
    int    idle_run = 0;
    int    viol = 0;
    logic [3:0] prev_data_rd = 4'b0000;

    int vectors = 0;
    int miscompares = 0;
    int obs_idx = 0;
    int exp_idx = 0;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bus.ptr_empty[k]           = (ptr_wr[k] == ptr_rdi[k]);
            bus.ptr_dout[k*16 +: 16]   = ptr_dout_r[k];
            bus.data_dout[k*128 +: 128] = data_r[k];
        end
    end
    assign bus.o_cell_bp = bp;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (fifo_clr) begin
                ptr_rdi[k] <= 0;
                dat_rdi[k] <= 0;
            end else begin
                if (bus.ptr_rd[k]) begin
                    ptr_dout_r[k] <= ptr_mem[k][ptr_rdi[k] % 64];
                    ptr_rdi[k]    <= ptr_rdi[k] + 1;
                end
                if (bus.data_rd[k]) begin
                    data_r[k]  <= data_mem[k][dat_rdi[k] % 1024];
                    dat_rdi[k] <= dat_rdi[k] + 1;
                end
            end
        end
    end

    function automatic int onehot_idx(input logic [3:0] v);
        int r = 0;
        for (int k = 0; k < 4; k++) if (v[k]) r = k;
        return r;
    endfunction

    // Output monitor and handshake invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.o_cell_wr) begin
            obs_q.push_back({bus.o_cell_data, bus.o_cell_sof, bus.o_cell_eof,
                             bus.o_cell_portmap, bus.o_cell_src});
            obs_cyc.push_back(cyc);
        end
        if (bus.ptr_rd != 4'b0000) begin
            ptr_cyc_q.push_back(cyc);
            ptr_port_q.push_back(onehot_idx(bus.ptr_rd));
        end
        if (bus.data_rd != 4'b0000) n_data_rd <= n_data_rd + 1;
        if (bus.ptr_rd != 4'b0000 || bus.data_rd != 4'b0000 || bus.o_cell_wr) idle_run <= 0;
        else idle_run <= idle_run + 1;
        if (($countones(bus.ptr_rd) > 1) || ($countones(bus.data_rd) > 1) ||
            (bus.ptr_rd != 4'b0000 && bus.data_rd != 4'b0000) ||
            (bus.data_rd != 4'b0000 && bus.o_cell_bp) ||
            (bus.o_cell_wr && prev_data_rd == 4'b0000))
            viol <= viol + 1;
        prev_data_rd <= bus.data_rd;
    end

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_cell(input string name, input cell_t act, input cell_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input int p, input logic [3:0] pm, input int cnt);
        frm_t f;
        logic [127:0] d;
        for (int i = 0; i < cnt; i++) begin
            d = {32'(p), 32'(serial), $urandom(), $urandom()};
            serial++;
            data_mem[p][dat_wr[p] % 1024] = d;
            dat_wr[p]++;
            mdata[p].push_back(d);
        end
        // junk in the unused pointer bits must not leak into the frame
        ptr_mem[p][ptr_wr[p] % 64] = {4'($urandom()), pm, 2'($urandom()), 6'(cnt)};
        ptr_wr[p]++;
        f.pm  = pm;
        f.cnt = cnt;
        mq[p].push_back(f);
    endtask

    // Frames pushed together are served in round-robin order, each frame whole.
    task automatic model_arbitrate();
        int p;
        frm_t f;
        cell_t c;
        while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0) begin
            p = model_rr;
            while (mq[p].size() == 0) p = (p + 1) % 4;
            f = mq[p].pop_front();
            if (f.cnt == 0) begin
                if (err_exp < 65535) err_exp++;
            end else begin
                for (int i = 0; i < f.cnt; i++) begin
                    c.data = mdata[p].pop_front();
                    c.sof  = (i == 0);
                    c.eof  = (i == f.cnt - 1);
                    c.pm   = f.pm;
                    c.src  = 2'(p);
                    exp_q.push_back(c);
                end
            end
            model_rr = (p + 1) % 4;
        end
    endtask

    task automatic run_until_done(input bit rand_bp, input int budget);
        int n = 0;
        int run = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            if (rand_bp) begin
                if (run < 3 && $urandom_range(0, 2) == 0) begin
                    bp = 1'b1;
                    run++;
                end else begin
                    bp = 1'b0;
                    run = 0;
                end
            end
            tick();
            done = (&bus.ptr_empty) && (idle_run >= 6);
            n++;
        end
        bp = 1'b0;
        check_int("drain timeout", int'(done), 1);
    endtask

    task automatic compare_stream(input string name);
        int n_obs = obs_q.size() - obs_idx;
        int n_exp = exp_q.size() - exp_idx;
        for (int j = 0; j < n_exp && j < n_obs; j++)
            check_cell($sformatf("%s cell %0d", name, j), obs_q[obs_idx + j], exp_q[exp_idx + j]);
        check_int($sformatf("%s cell count", name), n_obs, n_exp);
        obs_idx = obs_q.size();
        exp_idx = exp_q.size();
    endtask

    task automatic run_frame_check(input string name, input int port, input logic [3:0] pm,
                                   input int cnt, input int exp_cells, input int exp_err);
        int t, sp, sr, so;
        tick();
        t  = cyc;
        sp = ptr_cyc_q.size();
        sr = n_data_rd;
        so = obs_q.size();
        push_frame(port, pm, cnt);
        model_arbitrate();
        run_until_done(1'b0, 200);
        check_int($sformatf("%s ptr_rd count", name), ptr_cyc_q.size() - sp, 1);
        if (ptr_cyc_q.size() > sp) begin
            check_int($sformatf("%s ptr_rd port", name), ptr_port_q[sp], port);
            check_int($sformatf("%s ptr_rd latency", name), ptr_cyc_q[sp] - t, 1);
        end
        check_int($sformatf("%s data_rd count", name), n_data_rd - sr, exp_cells);
        if (exp_cells > 0 && obs_q.size() > so) begin
            check_int($sformatf("%s first wr latency", name), obs_cyc[so] - t, 4);
            check_int($sformatf("%s last wr latency", name), obs_cyc[obs_q.size() - 1] - t, 3 + exp_cells);
        end
        compare_stream(name);
        check_int($sformatf("%s err_cnt", name), int'(bus.err_cnt), exp_err);
    endtask

    task automatic check_reset_outputs(input string name);
        check_int($sformatf("%s wr", name), int'(bus.o_cell_wr), 0);
        check_int($sformatf("%s sof/eof", name), int'({bus.o_cell_sof, bus.o_cell_eof}), 0);
        check_int($sformatf("%s data nonzero", name), int'(bus.o_cell_data != 128'd0), 0);
        check_int($sformatf("%s portmap", name), int'(bus.o_cell_portmap), 0);
        check_int($sformatf("%s src", name), int'(bus.o_cell_src), 0);
        check_int($sformatf("%s err_cnt", name), int'(bus.err_cnt), 0);
        check_int($sformatf("%s rd strobes", name), int'({bus.ptr_rd, bus.data_rd}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int t, sp, so, n;
        int exp_off[5];
        int rr_order[6];

        vecs[0] = '{2, 4'b0101, 3,  3,  0};
        vecs[1] = '{1, 4'b0011, 0,  0,  1};
        vecs[2] = '{1, 4'b1000, 1,  1,  1};
        vecs[3] = '{0, 4'b1111, 63, 63, 1};
        vecs[4] = '{3, 4'b0110, 2,  2,  1};

        repeat (3) @(posedge clk);
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        fifo_clr = 1'b0;

        foreach (vecs[i])
            run_frame_check($sformatf("vec%0d", i), vecs[i].port, vecs[i].pm, vecs[i].cnt,
                            vecs[i].exp_cells, vecs[i].exp_err);

        // round-robin: all four ports at once, then ports 0 and 3 after the wrap
        tick();
        sp = ptr_cyc_q.size();
        for (int p = 0; p < 4; p++) push_frame(p, 4'(p + 1), 2);
        model_arbitrate();
        run_until_done(1'b0, 200);
        compare_stream("rr all");
        push_frame(3, 4'b1010, 2);
        push_frame(0, 4'b0001, 2);
        model_arbitrate();
        run_until_done(1'b0, 200);
        compare_stream("rr refill");
        rr_order = '{0, 1, 2, 3, 0, 3};
        check_int("rr grant count", ptr_port_q.size() - sp, 6);
        for (int i = 0; i < 6 && sp + i < ptr_port_q.size(); i++)
            check_int($sformatf("rr grant %0d", i), ptr_port_q[sp + i], rr_order[i]);

        // backpressure for 3 cycles right after the 2nd data read
        tick();
        t  = cyc;
        so = obs_q.size();
        push_frame(2, 4'b1001, 5);
        model_arbitrate();
        while (cyc < t + 5) begin
            @(posedge clk);
            #1;
        end
        bp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bp = 1'b0;
        run_until_done(1'b0, 100);
        exp_off = '{4, 5, 9, 10, 11};
        for (int i = 0; i < 5 && so + i < obs_q.size(); i++)
            check_int($sformatf("bp wr cycle %0d", i), obs_cyc[so + i] - t, exp_off[i]);
        compare_stream("bp frame");

        // reset after two of six cells, then a fresh frame on port 3
        tick();
        so = obs_q.size();
        push_frame(1, 4'b0111, 6);
        model_arbitrate();
        n = 0;
        while (obs_q.size() < so + 2 && n < 50) begin
            tick();
            n++;
        end
        check_int("rst cells before reset", obs_q.size() - so, 2);
        for (int i = 0; i < 2 && so + i < obs_q.size(); i++)
            check_cell($sformatf("rst pre cell %0d", i), obs_q[so + i], exp_q[exp_idx + i]);
        rst = 1'b1;
        fifo_clr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ptr_wr[k] = 0;
            dat_wr[k] = 0;
        end
        tick();
        check_reset_outputs("mid-frame reset");
        rst = 1'b0;
        fifo_clr = 1'b0;
        model_rr = 0;
        err_exp = 0;
        obs_idx = obs_q.size();
        exp_idx = exp_q.size();
        run_frame_check("post-reset", 3, 4'b1100, 2, 2, 0);

        // random batches with random short backpressure bursts
        for (int b = 0; b < 25; b++) begin
            tick();
            for (int p = 0; p < 4; p++) begin
                n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) push_frame(p, 4'($urandom()), $urandom_range(0, 6));
            end
            model_arbitrate();
            run_until_done(1'b1, 600);
            compare_stream($sformatf("rand%0d", b));
            check_int($sformatf("rand%0d err_cnt", b), int'(bus.err_cnt), err_exp);
        end

        check_int("handshake violations", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
